// File: rtl/vga_timing_gen_if.sv
// Video timing bundle produced by vga_timing_gen and consumed by pixel logic.
// Downstream logic treats every field as valid only in clocks where p_tick is high.
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          p_tick;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          video_on;
    logic          hsync;
    logic          vsync;
    logic          line_tick;
    logic          frame_tick;
    logic [15:0]   frame_cnt;

    modport master (
        output p_tick, pixel_x, pixel_y, video_on, hsync, vsync,
               line_tick, frame_tick, frame_cnt
    );

    modport slave (
        input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync,
               line_tick, frame_tick, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-enable divider, h/v counters, syncs, strobes.
// Optional frame counter is built only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int DIV      = 2,
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 10
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic          tick;
    logic          line_end;
    logic          frame_end;
    logic [CW-1:0] h_cnt, v_cnt;
    logic [CW-1:0] h_next, v_next;
    logic          video_on_q, hsync_q, vsync_q;

    generate
        if (DIV > 1) begin : g_div
            logic [DW-1:0] div_cnt;
            always_ff @(posedge clk) begin
                if (reset)
                    div_cnt <= '0;
                else if (div_cnt == DW'(DIV - 1))
                    div_cnt <= '0;
                else
                    div_cnt <= div_cnt + 1'b1;
            end
            assign tick = (div_cnt == DW'(DIV - 1));
        end else begin : g_nodiv
            assign tick = 1'b1;
        end
    endgenerate

    assign line_end  = tick && (h_cnt == CW'(H_TOTAL - 1));
    assign frame_end = line_end && (v_cnt == CW'(V_TOTAL - 1));

    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (tick) begin
            if (h_cnt == CW'(H_TOTAL - 1)) begin
                h_next = '0;
                if (v_cnt == CW'(V_TOTAL - 1))
                    v_next = '0;
                else
                    v_next = v_cnt + 1'b1;
            end else begin
                h_next = h_cnt + 1'b1;
            end
        end
    end

    // Decode from the next-state counters so the registered flags line up with pixel_x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            video_on_q <= 1'b1;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
        end else begin
            h_cnt      <= h_next;
            v_cnt      <= v_next;
            video_on_q <= (h_next < CW'(H_DISP)) && (v_next < CW'(V_DISP));
            hsync_q    <= ((h_next >= CW'(H_DISP + H_FP)) &&
                           (h_next <  CW'(H_DISP + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
            vsync_q    <= ((v_next >= CW'(V_DISP + V_FP)) &&
                           (v_next <  CW'(V_DISP + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    always_ff @(posedge clk) begin
        if (reset)
            frame_cnt_q <= '0;
        else if (frame_end)
            frame_cnt_q <= frame_cnt_q + 16'd1;
    end
    assign vid.frame_cnt = frame_cnt_q;
`else
    assign vid.frame_cnt = '0;
`endif

    assign vid.p_tick     = tick;
    assign vid.pixel_x    = h_cnt;
    assign vid.pixel_y    = v_cnt;
    assign vid.video_on   = video_on_q;
    assign vid.hsync      = hsync_q;
    assign vid.vsync      = vsync_q;
    assign vid.line_tick  = line_end;
    assign vid.frame_tick = frame_end;
endmodule
